irq_ctrl: RTL and testbench

//  Parametrised interrupt controller. Replaces the per-source timer_int/ext_int wiring between

---
 rtl/irq_pkg.sv | 15 +
 rtl/irq_sync_edge.sv | 36 +++
 rtl/irq_ctrl.sv | 132 +++++++++++++
 tb/tb_irq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and
// fixed source indices used by the SoC wiring and the CPU CSR decode.
package irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2,
      ST_HOLD = 2'd3
   } irq_state_e;

   localparam int IRQ_TIMER = 0;
   localparam int IRQ_EXT   = 1;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser followed by a registered strobe.
// EDGE=1: one-cycle pulse on each synchronised rising edge.
// EDGE=0: registered copy of the synchronised level.
module irq_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic EDGE        = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_src,
   output logic o_strobe
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_strobe;
   logic                   w_s;

   assign w_s      = r_sync[SYNC_STAGES-1];
   assign o_strobe = r_strobe;

   // Shift the raw line through the synchroniser and form the strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync   <= '0;
         r_prev   <= 1'b0;
         r_strobe <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
         r_prev <= w_s;
         if (EDGE) r_strobe <= w_s & ~r_prev;
         else      r_strobe <= w_s;
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises NUM_SRC sources, latches edge or level
// requests, arbitrates with fixed lowest-index priority and runs the
// IDLE/REQ/ACK/HOLD handshake with the CPU.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int                 NUM_SRC     = 4,
   parameter logic [NUM_SRC-1:0] EDGE_MASK   = 4'b0011,
   parameter int                 SYNC_STAGES = 2,
   localparam int                ID_W        = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic [NUM_SRC-1:0] irq_en,
   input  logic               irq_ack,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_SRC-1:0] src_ack,
   output logic [NUM_SRC-1:0] pending
);

   localparam int CNT_W = $clog2(SYNC_STAGES + 1);

   irq_state_e         r_state, w_state_nxt;
   logic               r_req, w_req_nxt;
   logic [ID_W-1:0]    r_id, w_id_nxt;
   logic [NUM_SRC-1:0] r_src_ack, w_src_ack_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [NUM_SRC-1:0] r_pending, w_pending_nxt;
   logic [NUM_SRC-1:0] w_strobe, w_clr, w_elig;
   logic [ID_W-1:0]    w_win;
   logic               w_any;

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_src
         irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE        (EDGE_MASK[g])
         ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .i_src    (src_irq[g]),
            .o_strobe (w_strobe[g])
         );
      end
   endgenerate

   // Pending update: edge bits set-wins over the ACK clear, level bits follow the strobe.
   always_comb begin
      w_clr = '0;
      if (r_state == ST_ACK) w_clr = NUM_SRC'(1) << r_id;
      w_pending_nxt = (((r_pending & ~w_clr) | w_strobe) & EDGE_MASK)
                    | (w_strobe & ~EDGE_MASK);
   end

   // Fixed priority: scan downward so the lowest eligible index is left in w_win.
   always_comb begin
      w_elig = r_pending & irq_en;
      w_any  = |w_elig;
      w_win  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_elig[i]) w_win = ID_W'(i);
      end
   end

   // Next-state and registered-output decode for the CPU handshake.
   always_comb begin
      w_state_nxt   = r_state;
      w_req_nxt     = r_req;
      w_id_nxt      = r_id;
      w_src_ack_nxt = '0;
      w_cnt_nxt     = r_cnt;
      case (r_state)
         ST_IDLE: begin
            w_req_nxt = 1'b0;
            if (w_any) begin
               w_state_nxt = ST_REQ;
               w_req_nxt   = 1'b1;
               w_id_nxt    = w_win;
            end
         end
         ST_REQ: begin
            // Request stays up regardless of mask or level; only the ack ends it.
            if (irq_ack) begin
               w_state_nxt   = ST_ACK;
               w_req_nxt     = 1'b0;
               w_src_ack_nxt = NUM_SRC'(1) << r_id;
            end
         end
         ST_ACK: begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
         end
         ST_HOLD: begin
            // Blank long enough for a dropped level line to reach pending.
            if (r_cnt == CNT_W'(SYNC_STAGES)) w_state_nxt = ST_IDLE;
            else                              w_cnt_nxt   = r_cnt + 1'b1;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase
   end

   // State, handshake outputs and pending register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_req     <= 1'b0;
         r_id      <= '0;
         r_src_ack <= '0;
         r_cnt     <= '0;
         r_pending <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_req     <= w_req_nxt;
         r_id      <= w_id_nxt;
         r_src_ack <= w_src_ack_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   assign irq_req = r_req;
   assign irq_id  = r_id;
   assign src_ack = r_src_ack;
   assign pending = r_pending;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios plus random traffic against a latency-based reference model.
module tb_irq_ctrl;

   localparam logic [3:0] EMASK = 4'b0011;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] src_irq = '0;
   logic [3:0] irq_en = 4'hF;
   logic       irq_ack = 1'b0;
   logic       irq_req;
   logic [1:0] irq_id;
   logic [3:0] src_ack;
   logic [3:0] pending;

   int total = 0;
   int bad   = 0;

   irq_ctrl #(.NUM_SRC(4), .EDGE_MASK(EMASK), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .src_irq (src_irq),
      .irq_en  (irq_en),
      .irq_ack (irq_ack),
      .irq_req (irq_req),
      .irq_id  (irq_id),
      .src_ack (src_ack),
      .pending (pending)
   );

   always #5 clk = ~clk;

   // Reference model: hq holds the raw src samples of the last 5 edges (hq[0] newest).
   // A sample reaches pending 3 edges later. mbusy: 0 free, -1 presenting,
   // 4 = ack cycle, 3..1 = blanking cycles.
   logic [3:0] hq[$];
   logic [3:0] mp;
   int         mbusy;
   int         mid;
   logic [3:0] served[$];

   task automatic m_reset();
      hq.delete();
      for (int i = 0; i < 5; i++) hq.push_front(4'b0);
      mp = '0;
      mbusy = 0;
      mid = 0;
   endtask

   task automatic m_edge();
      logic [3:0] rise, clr, nxt, elig;
      hq.push_front(src_irq);
      void'(hq.pop_back());
      rise = hq[3] & ~hq[4];
      clr  = (mbusy == 4) ? 4'(1 << mid) : 4'b0;
      nxt  = (((mp & ~clr) | rise) & EMASK) | (hq[3] & ~EMASK);
      if (mbusy == 0) begin
         elig = mp & irq_en;
         if (elig != 0) begin
            for (int i = 3; i >= 0; i--) if (elig[i]) mid = i;
            mbusy = -1;
         end
      end else if (mbusy == -1) begin
         if (irq_ack) mbusy = 4;
      end else begin
         mbusy--;
      end
      mp = nxt;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) m_reset();
      else       m_edge();
      #1;
      if (src_ack != 0) served.push_back(src_ack);
      chk("req",  32'(irq_req), 32'(mbusy == -1));
      chk("id",   32'(irq_id),  32'(mid));
      chk("ack",  32'(src_ack), (mbusy == 4) ? (32'd1 << mid) : 32'd0);
      chk("pend", 32'(pending), 32'(mp));
   endtask

   task automatic run_serve(input int n);
      for (int i = 0; i < n; i++) begin
         irq_ack = irq_req;
         step();
      end
      irq_ack = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int c;
      c = 0;
      while (!irq_req && c < 20) begin
         step();
         c++;
      end
      chk(tag, 32'(irq_req), 32'd1);
   endtask

   initial begin
      int nreq;
      m_reset();
      #12;
      chk("rst_req",  32'(irq_req), 32'd0);
      chk("rst_ack",  32'(src_ack), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_id",   32'(irq_id),  32'd0);
      @(negedge clk) reset = 1'b0;
      repeat (3) step();

      // Single edge source: request appears exactly four edges after the sample.
      src_irq = 4'b0010; step(); src_irq = 4'b0;
      step(); step(); step();
      chk("t1_early", 32'(irq_req), 32'd0);
      step();
      chk("t1_req", 32'(irq_req), 32'd1);
      chk("t1_id",  32'(irq_id),  32'd1);
      step();
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      chk("t1_srcack", 32'(src_ack), 32'b0010);
      step();
      chk("t1_srcack_off", 32'(src_ack), 32'd0);
      chk("t1_pend1", 32'(pending[1]), 32'd0);
      run_serve(6);

      // Simultaneous edges: index 0 served first, then 1.
      served.delete();
      src_irq = 4'b0011; step(); src_irq = 4'b0;
      run_serve(30);
      chk("t2_count", 32'(served.size()), 32'd2);
      if (served.size() >= 2) begin
         chk("t2_first",  32'(served[0]), 32'b0001);
         chk("t2_second", 32'(served[1]), 32'b0010);
      end

      // Level source dropping on ack: no second request; held high: re-request.
      src_irq[3] = 1'b1;
      nreq = 0;
      while (!src_ack[3] && nreq < 20) begin
         irq_ack = irq_req; step(); nreq++;
      end
      irq_ack = 1'b0;
      chk("t3_ack_seen", 32'(src_ack[3]), 32'd1);
      src_irq[3] = 1'b0;
      nreq = 0;
      for (int i = 0; i < 15; i++) begin step(); nreq += int'(irq_req); end
      chk("t3_noreq", 32'(nreq), 32'd0);
      src_irq[3] = 1'b1;
      wait_req("t3_rereq");
      chk("t3_id", 32'(irq_id), 32'd3);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      src_irq[3] = 1'b0;
      run_serve(10);

      // Masked edge stays pending and is presented once re-enabled.
      irq_en = 4'b1101;
      src_irq = 4'b0010; step(); src_irq = 4'b0;
      nreq = 0;
      for (int i = 0; i < 10; i++) begin step(); nreq += int'(irq_req); end
      chk("t4_noreq", 32'(nreq), 32'd0);
      chk("t4_pend",  32'(pending[1]), 32'd1);
      irq_en = 4'hF;
      step();
      chk("t4_req", 32'(irq_req), 32'd1);
      chk("t4_id",  32'(irq_id),  32'd1);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      run_serve(8);

      // New edge on src 0 lands in its own ack cycle: set must win over clear.
      src_irq = 4'b0001; step(); src_irq = 4'b0;
      wait_req("t5_req");
      src_irq = 4'b0001; step(); src_irq = 4'b0;
      step();
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      chk("t5_srcack", 32'(src_ack), 32'b0001);
      served.delete();
      step();
      chk("t5_pend", 32'(pending[0]), 32'd1);
      run_serve(20);
      chk("t5_second", 32'(served.size()), 32'd1);
      if (served.size() >= 1) chk("t5_second_id", 32'(served[0]), 32'b0001);

      // Reset in REQ clears everything asynchronously; stray ack after release is ignored.
      src_irq = 4'b0100;
      wait_req("t6_req");
      chk("t6_id", 32'(irq_id), 32'd2);
      @(negedge clk); #2 reset = 1'b1;
      m_reset();
      #1;
      chk("t6_req0",  32'(irq_req), 32'd0);
      chk("t6_pend0", 32'(pending), 32'd0);
      chk("t6_ack0",  32'(src_ack), 32'd0);
      src_irq = 4'b0;
      repeat (3) step();
      @(negedge clk) reset = 1'b0;
      served.delete();
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      repeat (10) step();
      chk("t6_noack", 32'(served.size()), 32'd0);
      chk("t6_idle",  32'(irq_req), 32'd0);

      // Random traffic, every cycle checked against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) src_irq = src_irq ^ 4'($urandom);
         if ($urandom_range(0, 63) == 0) irq_en = 4'($urandom);
         irq_ack = irq_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
